// File: rtl/gcd_operand_feeder.sv
// gcd_operand_feeder: buffers operand pairs in a FIFO and issues them one at a time to a GCD core
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     operand pair stream handshake (in_ready = FIFO not full)
//   in_a, in_b            operand pair; pairs with a zero operand are dropped
//   go                    one-cycle start pulse to the GCD controller
//   a_out, b_out          operands to the datapath, held until the next issue
//   done                  core status level (high idle/finished, low computing)
//   busy                  a job is in flight
//   err_zero              one-cycle pulse after a zero-operand pair is dropped
//   count                 FIFO occupancy
//   job_count             completed jobs, wrapping
module gcd_operand_feeder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     go,
    output logic [WIDTH-1:0]         a_out,
    output logic [WIDTH-1:0]         b_out,
    input  logic                     done,
    output logic                     busy,
    output logic                     err_zero,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              job_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, GO, WAIT_START, WAIT_DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mem_a_q [DEPTH];
    logic [WIDTH-1:0]  mem_b_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [15:0]       job_q, job_d;
    logic              err_q;
    logic              accept, zero, push, pop;

    assign in_ready  = count_q != FULL;
    assign accept    = in_valid && in_ready;
    assign zero      = in_a == '0 || in_b == '0;
    assign push      = accept && !zero;
    assign pop       = state_q == IDLE && count_q != '0;
    assign count_d   = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign go        = state_q == GO;
    assign busy      = state_q != IDLE;
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign err_zero  = err_q;
    assign count     = count_q;
    assign job_count = job_q;

    // done is only consulted after GO, so the core's idle-high level is never mistaken for completion
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        job_d   = job_q;
        case (state_q)
            IDLE: if (pop) begin
                state_d = GO;
                a_d     = mem_a_q[rd_ptr_q];
                b_d     = mem_b_q[rd_ptr_q];
            end
            GO:         state_d = WAIT_START;
            WAIT_START: if (!done) state_d = WAIT_DONE;
            WAIT_DONE: if (done) begin
                state_d = IDLE;
                job_d   = job_q + 16'd1;
            end
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            job_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            a_q      <= a_d;
            b_q      <= b_d;
            job_q    <= job_d;
            err_q    <= accept && zero;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // storage needs no reset: occupancy alone decides which entries are valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= in_a;
            mem_b_q[wr_ptr_q] <= in_b;
        end
    end
endmodule

// File: doc/gcd_operand_feeder.md
# gcd_operand_feeder

Upstream feeder for the GCD controller/datapath pair. It accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. It issues one job at a time to the GCD core by presenting stable operands and a single-cycle `go`, then tracks the core's `done` level to detect job completion before issuing the next pair. Pairs with a zero operand are rejected at entry, because the core never terminates on them.

## Interface
- `WIDTH`, 8, operand width in bits.
- `DEPTH`, 4, FIFO entries; a power of 2 and at least 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  an operand pair is offered.
- `in_ready`  out  1  feeder can accept a pair; equals `!full`, combinational from the FIFO count.
- `in_a`, `in_b`  in  WIDTH  operand pair, sampled when `in_valid & in_ready`.
- `go`  out  1  start pulse to the GCD controller.
- `a_out`, `b_out`  out  WIDTH  operands to the datapath; held stable from the `go` cycle until the next issue.
- `done`  in  1  core status level: high when idle or finished, low while computing.
- `busy`  out  1  a job is in flight (state is not IDLE).
- `err_zero`  out  1  one-cycle pulse when a pair with a zero operand is dropped.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `job_count`  out  16  completed jobs; wraps 0xFFFF to 0.

## Operation
- **Push.** On `in_valid & in_ready` with both operands non-zero, the pair is written at the write pointer and `count` increments.
- **Zero reject.** If `in_a == 0` or `in_b == 0`, the handshake still completes, but nothing is stored. `err_zero` is 1 in the following cycle.
- **FIFO pointers.** Read and write pointers wrap modulo `DEPTH`. A push and a pop on the same edge leave `count` unchanged. When full, `in_ready` is 0 and no push occurs, even if a pop happens on the same edge.
- **FSM states:**
  - IDLE: if `count > 0`, load `a_out`/`b_out` from the FIFO head, pop it, drive `go <= 1`, and go to GO.
  - GO: drive `go <= 0` and go to WAIT_START.
  - WAIT_START: wait for `done == 0`, which confirms the core has started; then go to WAIT_DONE.
  - WAIT_DONE: wait for `done == 1`; then increment `job_count` and go to IDLE.
- **`done` filtering.** `done` is ignored in IDLE and GO. The core holds `done` high while idle, so the initial high level must not be taken as completion.
- **Reset.** A synchronous reset, including one mid-job, clears the FIFO and forces IDLE. Reset values:
  - `go = 0`, `busy = 0`, `err_zero = 0`;
  - `a_out = 0`, `b_out = 0`;
  - `count = 0`, `job_count = 0`;
  - `in_ready = 1` in the first cycle after reset.

## Timing
- **Push to issue.** A pair pushed at edge k is visible at the FIFO head after k. With the FSM in IDLE, `go` and the new `a_out`/`b_out` appear after edge k+1. First-issue latency is 2 cycles from the accepting edge.
- **`go` width.** `go` is high for exactly 1 cycle.
- **Operand stability.** `a_out`/`b_out` change only at an IDLE→GO edge.
- **Completion.** WAIT_DONE→IDLE occurs on the first edge at which `done` is sampled high. `job_count` updates on that same edge.
- **Back-to-back issue.** The next `go` is asserted no earlier than 1 cycle after the completion edge. The controller sees `go` while in its idle state.
- **`busy`.** `busy` is 1 in GO, WAIT_START and WAIT_DONE.
- **Capacity.** An issued pair leaves the FIFO at issue, so up to DEPTH+1 pairs can be outstanding: DEPTH queued plus one in flight.

## Test plan
- **Single job.** Push (48,18) with `done` = 1. Required:
  - `go` = 1 for one cycle, 2 cycles after the accepting edge, with `a_out` = 48 and `b_out` = 18.
  - Drive `done` low for 4 cycles, then high: `job_count` = 1, `busy` = 0.
- **Zero reject.** Push (0,5), then (7,0). Required:
  - two `err_zero` pulses;
  - `count` stays 0 and no `go` is issued;
  - `in_ready` stays 1.
- **Full FIFO, DEPTH = 4, core held busy.** Push 6 pairs (1,1)…(6,6) with `done` held low after the first start. Required:
  - pair 1 is issued and pairs 2–5 are queued (`count` = 4);
  - `in_ready` = 0 and pair 6 stalls;
  - after `done` rises, pair 2 issues and pair 6 is accepted.
- **Back-to-back.** Queue (12,8) and (9,6), and model the core's `done` sequence (high, low, high). Required:
  - operands are issued in FIFO order;
  - the second `go` comes ≥1 cycle after the first completion;
  - `job_count` = 2.
- **Reset mid-job.** Assert `rst` in WAIT_DONE with 2 pairs queued. Required, on the cycle after the reset edge:
  - `count` = 0, `busy` = 0, `go` = 0;
  - `a_out` = 0, `b_out` = 0, `job_count` = 0;
  - no `go` is issued until a new push.
- **Simultaneous push and pop.** A push coinciding with an issue from IDLE when `count` = 2. Required: `count` stays 2 and the pointers wrap correctly past entry DEPTH-1.
